// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the control unit, muldiv_ctrl and the iterative
// Mult/Div units; the slave modport is the sequencer's view.
interface muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WData;
  logic [WIDTH-1:0] UnitA;
  logic [WIDTH-1:0] UnitB;
  logic             MultStart;
  logic             DivStart;
  logic             UnitStop;
  logic [WIDTH-1:0] UnitHigh;
  logic [WIDTH-1:0] UnitLow;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic             Timeout;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WData, UnitStop, UnitHigh, UnitLow,
    input  UnitA, UnitB, MultStart, DivStart, Busy, Done, DivZero, Timeout, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WData, UnitStop, UnitHigh, UnitLow,
    output UnitA, UnitB, MultStart, DivStart, Busy, Done, DivZero, Timeout, HI, LO
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative Mult/Div units: strips operand signs, launches a
// unit, restores result signs and owns the architectural HI/LO registers.
module muldiv_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          Reset,
  muldiv_ctrl_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXC,
    S_LAUNCH,
    S_WAIT,
    S_FIXUP,
    S_WRITE
  } state_t;

  state_t state, state_n;

  logic             op_div;
  logic             neg_p;
  logic             neg_r;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    prod_neg;
  logic             is_signed;
  logic             div_zero_req;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    is_signed    = ~bus.Op[0];
    div_zero_req = bus.Op[1] && (bus.B == '0);
    prod_neg     = ~{res_hi, res_lo} + W2'(1);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.Start) state_n = div_zero_req ? S_EXC : S_LAUNCH;
      S_EXC:    state_n = S_IDLE;
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        // completion in the final allowed cycle still wins over the abort
        if (bus.UnitStop)         state_n = S_FIXUP;
        else if (cnt == CNT_LAST) state_n = S_IDLE;
      end
      S_FIXUP:  state_n = S_WRITE;
      S_WRITE:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Busy      = (state != S_IDLE);
    bus.DivZero   = (state == S_EXC);
    bus.MultStart = (state == S_LAUNCH) && !op_div;
    bus.DivStart  = (state == S_LAUNCH) && op_div;
    bus.Done      = (state == S_WRITE);
    bus.Timeout   = (state == S_WAIT) && !bus.UnitStop && (cnt == CNT_LAST);
    bus.UnitA     = unit_a;
    bus.UnitB     = unit_b;
    bus.HI        = hi_q;
    bus.LO        = lo_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      op_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      unit_a <= '0;
      unit_b <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            if (!div_zero_req) begin
              op_div <= bus.Op[1];
              neg_p  <= is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_r  <= is_signed & bus.A[WIDTH-1];
              unit_a <= magnitude(bus.A, is_signed);
              unit_b <= magnitude(bus.B, is_signed);
            end
          end else begin
            if (bus.HiWrite) hi_q <= bus.WData;
            if (bus.LoWrite) lo_q <= bus.WData;
          end
        end
        S_LAUNCH: cnt <= '0;
        S_WAIT: begin
          if (bus.UnitStop) begin
            res_hi <= bus.UnitHigh;
            res_lo <= bus.UnitLow;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIXUP: begin
          if (!op_div) begin
            if (neg_p) {res_hi, res_lo} <= prod_neg;
          end else begin
            if (neg_p) res_lo <= ~res_lo + WIDTH'(1);
            if (neg_r) res_hi <= ~res_hi + WIDTH'(1);
          end
        end
        S_WRITE: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: timeline model of the sequencer, a functional
// Mult/Div unit stub with programmable latency, and directed vectors.
module tb_muldiv_ctrl;
  localparam int unsigned W  = 32;
  localparam int          TO = 64;
  localparam int          NEVER = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic Reset;
  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state: absolute edge indices at which events must be visible.
  int cyc = 0, t_free = 0, s_at = -100, launch_at = -100;
  int done_at = -100, write_at = -100, dz_at = -100;
  bit pend = 1'b0;
  logic [1:0]  p_op = '0;
  logic [31:0] p_a = '0, p_b = '0;
  logic [31:0] m_hi = '0, m_lo = '0, m_ua = '0, m_ub = '0;
  logic [63:0] w_res = '0;

  int stub_lat = 33;

  int n_done = 0, n_dz = 0, n_ms = 0, n_ds = 0, n_to = 0, n_busy = 0;
  int done_cyc = 0, to_cyc = 0;

  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] v);
    if (!op[0] && $signed(v) < 0) return 32'(-longint'($signed(v)));
    return v;
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'h0, a} * {32'h0, b};
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pend = 1'b0; t_free = cyc;
      launch_at = -100; done_at = -100; write_at = -100; dz_at = -100;
      m_hi = '0; m_lo = '0; m_ua = '0; m_ub = '0;
    end else begin
      cyc++;
      if (pend && cyc >= s_at + 2) begin
        if (bus.UnitStop === 1'b1) begin
          pend = 1'b0; done_at = cyc + 1; write_at = cyc + 2; t_free = cyc + 2;
          w_res = ref_result(p_op, p_a, p_b);
        end else if (cyc == s_at + TO + 1) begin
          pend = 1'b0; t_free = cyc;
        end
      end
      if (cyc == write_at) begin
        m_hi = w_res[63:32];
        m_lo = w_res[31:0];
      end
      if (cyc > t_free) begin
        if (bus.Start) begin
          if (bus.Op[1] && bus.B == 32'h0) begin
            dz_at = cyc; t_free = cyc + 1;
          end else begin
            pend = 1'b1; s_at = cyc; launch_at = cyc; t_free = NEVER;
            p_op = bus.Op; p_a = bus.A; p_b = bus.B;
            m_ua = mag(bus.Op, bus.A);
            m_ub = mag(bus.Op, bus.B);
          end
        end else begin
          if (bus.HiWrite) m_hi = bus.WData;
          if (bus.LoWrite) m_lo = bus.WData;
        end
      end
    end
  end

  // Unit stub: real unsigned arithmetic on UnitA/UnitB, UnitStop high in the
  // cycle stub_lat+1 edges after the launch became visible (never if < 0).
  initial begin : unit_stub
    int cnt;
    bit run;
    logic [63:0] res;
    cnt = 0; run = 1'b0; res = '0;
    bus.UnitStop = 1'b0; bus.UnitHigh = '0; bus.UnitLow = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.UnitStop = 1'b0;
      if (bus.MultStart || bus.DivStart) begin
        run = 1'b1; cnt = 0;
        if (bus.DivStart)
          res = (bus.UnitB == 0) ? 64'h0 : {bus.UnitA % bus.UnitB, bus.UnitA / bus.UnitB};
        else
          res = {32'h0, bus.UnitA} * {32'h0, bus.UnitB};
      end else if (run) begin
        cnt++;
        if (stub_lat >= 0 && cnt == stub_lat + 1) begin
          bus.UnitStop = 1'b1;
          {bus.UnitHigh, bus.UnitLow} = res;
          run = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_cycle();
    check("Busy", bus.Busy, cyc < t_free);
    check("Done", bus.Done, cyc == done_at);
    check("DivZero", bus.DivZero, cyc == dz_at);
    check("MultStart", bus.MultStart, cyc == launch_at && !p_op[1]);
    check("DivStart", bus.DivStart, cyc == launch_at && p_op[1]);
    check("Timeout", bus.Timeout, pend && cyc == s_at + TO && bus.UnitStop == 1'b0);
    check("HI", bus.HI, m_hi);
    check("LO", bus.LO, m_lo);
    check("UnitA", bus.UnitA, m_ua);
    check("UnitB", bus.UnitB, m_ub);
    if (bus.Done === 1'b1)      begin n_done++; done_cyc = cyc; end
    if (bus.Timeout === 1'b1)   begin n_to++; to_cyc = cyc; end
    if (bus.DivZero === 1'b1)   n_dz++;
    if (bus.MultStart === 1'b1) n_ms++;
    if (bus.DivStart === 1'b1)  n_ds++;
    if (bus.Busy === 1'b1)      n_busy++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int s);
    bus.Op = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.Busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_wait_busy", bus.Busy, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s;
    int b_done, b_dz, b_ms, b_ds, b_to, b_busy;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WData = '0;
    tick(); tick();
    check("reset_busy", bus.Busy, 1'b0);
    check("reset_hi", bus.HI, 32'h0);
    check("reset_lo", bus.LO, 32'h0);
    Reset = 1'b1;
    tick();

    // DIV -7 / 2
    stub_lat = 33;
    b_done = n_done; b_ds = n_ds; b_ms = n_ms;
    issue(2'b10, 32'hFFFF_FFF9, 32'h2, s);
    check("div_unit_a", bus.UnitA, 32'd7);
    check("div_unit_b", bus.UnitB, 32'd2);
    wait_idle(100);
    check("div_start_pulses", n_ds - b_ds, 1);
    check("div_mult_pulses", n_ms - b_ms, 0);
    check("div_done_pulses", n_done - b_done, 1);
    check("div_write_edge", done_cyc + 1 - s, 37);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);

    // DIVU by zero
    b_done = n_done; b_ds = n_ds; b_dz = n_dz; b_busy = n_busy;
    issue(2'b11, 32'd5, 32'd0, s);
    wait_idle(10);
    tick();
    check("dz_pulses", n_dz - b_dz, 1);
    check("dz_div_start", n_ds - b_ds, 0);
    check("dz_done", n_done - b_done, 0);
    check("dz_busy_cycles", n_busy - b_busy, 1);
    check("dz_hi", bus.HI, 32'hFFFF_FFFF);
    check("dz_lo", bus.LO, 32'hFFFF_FFFD);

    // MULT -3 * 5, then MULTU 0xFFFFFFFF * 2
    stub_lat = 5;
    b_ms = n_ms;
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, s);
    wait_idle(30);
    check("mult_start_pulses", n_ms - b_ms, 1);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFF1);
    tick();
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, s);
    check("multu_unit_a", bus.UnitA, 32'hFFFF_FFFF);
    wait_idle(30);
    check("multu_hi", bus.HI, 32'h1);
    check("multu_lo", bus.LO, 32'hFFFF_FFFE);

    // Signed divide overflow case and other sign combinations
    stub_lat = 33;
    tick();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, s);
    check("ovf_unit_a", bus.UnitA, 32'h8000_0000);
    check("ovf_unit_b", bus.UnitB, 32'h1);
    wait_idle(100);
    check("ovf_lo", bus.LO, 32'h8000_0000);
    check("ovf_hi", bus.HI, 32'h0);
    tick();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, s);
    wait_idle(100);
    check("div_pos_neg_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_pos_neg_hi", bus.HI, 32'h1);
    // Start wins over a simultaneous MTHI in IDLE
    tick();
    bus.HiWrite = 1'b1; bus.WData = 32'hDEAD_BEEF;
    issue(2'b11, 32'd100, 32'd7, s);
    bus.HiWrite = 1'b0;
    wait_idle(100);
    check("divu_lo", bus.LO, 32'd14);
    check("divu_hi", bus.HI, 32'd2);
    stub_lat = 2;
    tick();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    wait_idle(30);
    check("mult_negneg_lo", bus.LO, 32'h1);
    check("mult_negneg_hi", bus.HI, 32'h0);

    // Hung unit
    stub_lat = -1;
    tick();
    b_to = n_to; b_busy = n_busy; b_done = n_done;
    issue(2'b01, 32'd10, 32'd20, s);
    wait_idle(200);
    tick();
    check("to_pulses", n_to - b_to, 1);
    check("to_cycle", to_cyc - s, 64);
    check("to_busy_cycles", n_busy - b_busy, 65);
    check("to_done", n_done - b_done, 0);
    check("to_hi", bus.HI, 32'h0);
    check("to_lo", bus.LO, 32'h1);

    // Start and MTHI while busy are dropped; MTLO in IDLE lands next edge
    stub_lat = 10;
    b_dz = n_dz; b_ms = n_ms;
    issue(2'b01, 32'd6, 32'd7, s);
    bus.Start = 1'b1; bus.Op = 2'b10; bus.A = 32'd1; bus.B = 32'd0;
    bus.HiWrite = 1'b1; bus.WData = 32'hDEAD_BEEF;
    repeat (3) tick();
    bus.Start = 1'b0; bus.HiWrite = 1'b0;
    wait_idle(40);
    check("busy_ign_dz", n_dz - b_dz, 0);
    check("busy_ign_ms", n_ms - b_ms, 1);
    check("busy_ign_hi", bus.HI, 32'h0);
    check("busy_ign_lo", bus.LO, 32'd42);
    tick();
    bus.LoWrite = 1'b1; bus.WData = 32'h1234;
    tick();
    bus.LoWrite = 1'b0;
    check("mtlo_lo", bus.LO, 32'h1234);
    check("mtlo_hi", bus.HI, 32'h0);

    // Asynchronous reset mid-operation, late UnitStop afterwards
    stub_lat = 20;
    tick();
    issue(2'b10, 32'd50, 32'd3, s);
    repeat (5) tick();
    @(posedge clk);
    #3;
    Reset = 1'b0;
    #1;
    check("arst_busy", bus.Busy, 1'b0);
    check("arst_hi", bus.HI, 32'h0);
    check("arst_lo", bus.LO, 32'h0);
    check("arst_div_start", bus.DivStart, 1'b0);
    check("arst_unit_a", bus.UnitA, 32'h0);
    tick();
    Reset = 1'b1;
    b_done = n_done;
    repeat (30) tick();
    check("late_stop_done", n_done - b_done, 0);
    check("late_stop_lo", bus.LO, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
